// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// SpiFrameRx: SPI slave receiver that assembles fixed-length frames from an
// externally clocked SPI bus and hands them to a consumer over a valid/ready
// handshake.
//
// Ports
//   clk          system clock (40 MHz nominal)
//   reset        asynchronous, active-high reset
//   sclk, sdi    SPI clock and MSB-first data from the master, asynchronous
//   frame_data   last completed frame
//   frame_valid  frame_data holds an unconsumed frame
//   frame_ready  consumer accepts the frame when frame_valid is also high
//   overrun      sticky flag: a completed frame was dropped
//   frame_error  one-cycle pulse when a partial frame is aborted by timeout
//   bit_count    bits received so far in the current frame
//   busy         high while bit_count is non-zero
// -----------------------------------------------------------------------------
module spi_frame_rx #(
  parameter int FRAME_BITS     = 32,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int SYNC_STAGES    = 2,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sclk,
  input  logic                            sdi,
  output logic [FRAME_BITS-1:0]           frame_data,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic                            overrun,
  output logic                            frame_error,
  output logic [$clog2(FRAME_BITS+1)-1:0] bit_count,
  output logic                            busy
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic IDLE_LEVEL     = (CPOL != 0);
  localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);
  localparam logic [CW-1:0] LAST_BIT    = CW'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   sclk_d;
  logic                   sdi_d;
  logic                   rise;
  logic                   fall;
  logic                   sample_edge;
  logic                   sample_pulse;
  logic                   any_pulse;
  logic [TW-1:0]          idle_cnt;
  logic                   timeout_hit;
  logic [FRAME_BITS-2:0]  shift_reg;
  logic [FRAME_BITS-1:0]  new_word;
  logic                   complete;
  logic                   abort;
  logic                   accept;
  state_t                 state;
  state_t                 state_next;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_d;
  assign fall        = ~sclk_s & sclk_d;
  assign sample_edge = SAMPLE_ON_RISE ? rise : fall;

  // Synchronisers and edge detection. The detected edges are registered, and
  // sdi is delayed by one more flop so it stays aligned with the registered
  // sample pulse. Resetting the sclk flops to the idle level means a bus
  // resting at CPOL never looks like an edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync    <= {SYNC_STAGES{IDLE_LEVEL}};
      sdi_sync     <= '0;
      sclk_d       <= IDLE_LEVEL;
      sdi_d        <= 1'b0;
      sample_pulse <= 1'b0;
      any_pulse    <= 1'b0;
    end else begin
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync     <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_d       <= sclk_s;
      sdi_d        <= sdi_s;
      sample_pulse <= sample_edge;
      any_pulse    <= rise | fall;
    end
  end

  // Idle counter: any sclk edge restarts it, otherwise it saturates. An edge
  // in the expiry cycle wins, so expiry is masked by any_pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (any_pulse) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_MAX) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout_hit = (idle_cnt == TIMEOUT_MAX) && !any_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_pulse) begin
          state_next = RECV;
        end
      end
      RECV: begin
        if (sample_pulse && (bit_count == LAST_BIT)) begin
          state_next = IDLE;
          complete   = 1'b1;
        end else if (timeout_hit) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The final bit goes straight from sdi_d into the completed word, so the
  // shift register only needs to hold the first FRAME_BITS-1 bits.
  assign new_word = {shift_reg, sdi_d};
  assign accept   = frame_valid & frame_ready;
  assign busy     = (bit_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_count   <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= abort;
      if (abort || complete) begin
        shift_reg <= '0;
        bit_count <= '0;
      end else if (sample_pulse) begin
        shift_reg <= {shift_reg[FRAME_BITS-3:0], sdi_d};
        bit_count <= bit_count + CW'(1);
      end
    end
  end

  // Output handshake. A completion that coincides with an accept replaces the
  // frame; a completion while the old frame is still pending is dropped and
  // flagged as an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (complete && (!frame_valid || frame_ready)) begin
        frame_data  <= new_word;
        frame_valid <= 1'b1;
      end else if (accept) begin
        frame_valid <= 1'b0;
      end
      if (complete && frame_valid && !frame_ready) begin
        overrun <= 1'b1;
      end else if (accept) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_rx: directed self-checking bench for spi_frame_rx.
// Three instances cover mode 0 (full feature set), CPOL=1/CPHA=0 and
// CPOL=0/CPHA=1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_rx;

  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        sclk_v [3];
  logic        sdi_v  [3];
  logic        ready0;
  logic [31:0] frame_data0, frame_data1, frame_data2;
  logic        frame_valid0, frame_valid1, frame_valid2;
  logic        overrun0, overrun1, overrun2;
  logic        frame_error0, frame_error1, frame_error2;
  logic [5:0]  bit_count0, bit_count1, bit_count2;
  logic        busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sample_cyc = 0;
  int valid_rise_cyc = 0;
  int valid_high_cnt = 0;
  int err_cnt = 0;
  int err_saved = 0;
  logic [31:0] captured0 = '0;
  logic prev_valid0 = 1'b0;

  spi_frame_rx #(.CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk_v[0]), .sdi(sdi_v[0]),
    .frame_data(frame_data0), .frame_valid(frame_valid0), .frame_ready(ready0),
    .overrun(overrun0), .frame_error(frame_error0), .bit_count(bit_count0), .busy(busy0));

  spi_frame_rx #(.CPOL(1), .CPHA(0)) dut1 (
    .clk(clk), .reset(reset), .sclk(sclk_v[1]), .sdi(sdi_v[1]),
    .frame_data(frame_data1), .frame_valid(frame_valid1), .frame_ready(1'b1),
    .overrun(overrun1), .frame_error(frame_error1), .bit_count(bit_count1), .busy(busy1));

  spi_frame_rx #(.CPOL(0), .CPHA(1)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclk_v[2]), .sdi(sdi_v[2]),
    .frame_data(frame_data2), .frame_valid(frame_valid2), .frame_ready(1'b1),
    .overrun(overrun2), .frame_error(frame_error2), .bit_count(bit_count2), .busy(busy2));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe dut0 between clock edges: frame capture, valid duration,
  // valid rise time and frame_error pulses.
  always @(negedge clk) begin
    if (frame_valid0) begin
      valid_high_cnt = valid_high_cnt + 1;
      captured0 = frame_data0;
      if (!prev_valid0) valid_rise_cyc = cyc;
    end
    if (frame_error0) err_cnt = err_cnt + 1;
    prev_valid0 = frame_valid0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the top nbits of data MSB first on instance sel. With pulse_ready
  // set, ready0 is raised for exactly the cycle in which the final bit
  // completes the frame inside dut0.
  task automatic applyStimulus(input int sel, input logic [31:0] data, input int nbits,
                               input bit pulse_ready);
    logic cpol;
    logic cpha;
    cpol = (sel == 1);
    cpha = (sel == 2);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sdi_v[sel] = data[31-i];
        waitCycles(H);
        sclk_v[sel] = ~cpol;
        if (sel == 0) last_sample_cyc = cyc;
        if (pulse_ready && (i == nbits - 1)) begin
          waitCycles(3);
          ready0 = 1'b1;
          waitCycles(1);
          ready0 = 1'b0;
        end else begin
          waitCycles(H);
        end
        sclk_v[sel] = cpol;
      end else begin
        sclk_v[sel] = ~cpol;
        sdi_v[sel] = data[31-i];
        waitCycles(H);
        sclk_v[sel] = cpol;
        if (sel == 0) last_sample_cyc = cyc;
        waitCycles(H);
      end
    end
    waitCycles(H);
  endtask

  initial begin
    reset = 1'b1;
    ready0 = 1'b1;
    sclk_v[0] = 1'b0; sclk_v[1] = 1'b1; sclk_v[2] = 1'b0;
    sdi_v[0] = 1'b0; sdi_v[1] = 1'b0; sdi_v[2] = 1'b0;
    waitCycles(4);

    checkOutput("rst_data", 64'(frame_data0), 64'd0);
    checkOutput("rst_valid", 64'(frame_valid0), 64'd0);
    checkOutput("rst_overrun", 64'(overrun0), 64'd0);
    checkOutput("rst_bitcount", 64'(bit_count0), 64'd0);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_error", 64'(frame_error0), 64'd0);

    reset = 1'b0;
    waitCycles(10);
    checkOutput("idle_cpol1_no_edge", 64'(bit_count1), 64'd0);
    checkOutput("idle_cpol0_no_edge", 64'(bit_count0), 64'd0);

    // Basic mode-0 frame with an always-ready consumer.
    valid_high_cnt = 0;
    applyStimulus(0, 32'hA5C3_0F81, 32, 1'b0);
    waitCycles(10);
    checkOutput("basic_data", 64'(captured0), 64'hA5C3_0F81);
    checkOutput("basic_valid_cycles", 64'(valid_high_cnt), 64'd1);
    checkOutput("basic_latency", 64'(valid_rise_cyc - last_sample_cyc), 64'd4);
    checkOutput("basic_overrun", 64'(overrun0), 64'd0);

    // Consumer stalled: second frame must be dropped.
    ready0 = 1'b0;
    applyStimulus(0, 32'h0000_0001, 32, 1'b0);
    applyStimulus(0, 32'h0000_0002, 32, 1'b0);
    waitCycles(10);
    checkOutput("ovr_data_kept", 64'(frame_data0), 64'h0000_0001);
    checkOutput("ovr_valid", 64'(frame_valid0), 64'd1);
    checkOutput("ovr_flag", 64'(overrun0), 64'd1);
    ready0 = 1'b1;
    waitCycles(1);
    checkOutput("ovr_accept_valid", 64'(frame_valid0), 64'd0);
    checkOutput("ovr_accept_flag", 64'(overrun0), 64'd0);

    // Partial frame followed by a long idle gap.
    err_cnt = 0;
    applyStimulus(0, 32'hFFF8_0000, 13, 1'b0);
    checkOutput("partial_bitcount", 64'(bit_count0), 64'd13);
    checkOutput("partial_busy", 64'(busy0), 64'd1);
    waitCycles(8050);
    checkOutput("timeout_err_pulses", 64'(err_cnt), 64'd1);
    checkOutput("timeout_bitcount", 64'(bit_count0), 64'd0);
    checkOutput("timeout_busy", 64'(busy0), 64'd0);
    checkOutput("timeout_valid", 64'(frame_valid0), 64'd0);
    applyStimulus(0, 32'hDEAD_BEEF, 32, 1'b0);
    waitCycles(10);
    checkOutput("after_timeout_data", 64'(captured0), 64'hDEAD_BEEF);
    checkOutput("after_timeout_err", 64'(err_cnt), 64'd1);

    // Falling-edge sampling modes.
    applyStimulus(1, 32'h0000_0001, 32, 1'b0);
    applyStimulus(2, 32'h0000_0001, 32, 1'b0);
    waitCycles(10);
    checkOutput("cpol1_data_1", 64'(frame_data1), 64'h0000_0001);
    checkOutput("cpha1_data_1", 64'(frame_data2), 64'h0000_0001);
    applyStimulus(1, 32'hF0E1_D2C3, 32, 1'b0);
    applyStimulus(2, 32'h8C4A_2E17, 32, 1'b0);
    waitCycles(10);
    checkOutput("cpol1_data_2", 64'(frame_data1), 64'hF0E1_D2C3);
    checkOutput("cpha1_data_2", 64'(frame_data2), 64'h8C4A_2E17);
    checkOutput("cpol1_overrun", 64'(overrun1), 64'd0);

    // Completion in the same cycle as an accept of the previous frame.
    ready0 = 1'b0;
    applyStimulus(0, 32'h1111_1111, 32, 1'b0);
    waitCycles(10);
    checkOutput("same_first_data", 64'(frame_data0), 64'h1111_1111);
    applyStimulus(0, 32'h2222_2222, 32, 1'b1);
    checkOutput("same_new_data", 64'(frame_data0), 64'h2222_2222);
    checkOutput("same_valid", 64'(frame_valid0), 64'd1);
    checkOutput("same_overrun", 64'(overrun0), 64'd0);
    ready0 = 1'b1;
    waitCycles(1);
    checkOutput("same_final_accept", 64'(frame_valid0), 64'd0);

    // Reset in the middle of a frame.
    applyStimulus(0, 32'hABCD_E000, 20, 1'b0);
    checkOutput("midrst_bitcount_before", 64'(bit_count0), 64'd20);
    err_saved = err_cnt;
    reset = 1'b1;
    #1;
    checkOutput("midrst_data", 64'(frame_data0), 64'd0);
    checkOutput("midrst_valid", 64'(frame_valid0), 64'd0);
    checkOutput("midrst_overrun", 64'(overrun0), 64'd0);
    checkOutput("midrst_bitcount", 64'(bit_count0), 64'd0);
    checkOutput("midrst_busy", 64'(busy0), 64'd0);
    checkOutput("midrst_error", 64'(frame_error0), 64'd0);
    waitCycles(3);
    reset = 1'b0;
    waitCycles(10);
    checkOutput("midrst_no_err_pulse", 64'(err_cnt), 64'(err_saved));
    applyStimulus(0, 32'h1234_5678, 32, 1'b0);
    waitCycles(10);
    checkOutput("after_rst_data", 64'(captured0), 64'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
